spmv_vec_prefetch: RTL and testbench

SPMV_VEC_PREFETCH -- requirements
Module: spmv_vec_prefetch

---
 rtl/spmv_vec_prefetch.sv | 188 ++++++++++++++++++
 tb/tb_spmv_vec_prefetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_vec_prefetch.sv
// spmv_vec_prefetch: fetches a dense vector into an on-chip line buffer
// before SpMV compute starts, then serves 32-bit element reads to the
// compute channels.
//
// Optional feature: define SPMV_PF_MULTI_OUTSTANDING_EN to allow up to MAX_OUT
// reads in flight. The default build keeps a single read outstanding.
//
// States:
//   state   | meaning
//   IDLE    | waiting for start; start_rdy = 1
//   ISSUE   | issuing line reads k = 0 .. nlines-1
//   WAIT    | all reads issued, draining responses
//   DONE    | one cycle; raises done, marks the buffer loaded
module spmv_vec_prefetch #(
  parameter int MAX_LINES = 16,
  parameter int MAX_OUT   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_val,
  output logic                              start_rdy,
  input  logic [39:0]                       start_addr,
  input  logic [15:0]                       start_len,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              mem_req_val,
  input  logic                              mem_req_rdy,
  output logic [5:0]                        mem_req_transid,
  output logic [39:0]                       mem_req_addr,
  input  logic                              mem_resp_val,
  input  logic [5:0]                        mem_resp_transid,
  input  logic [511:0]                      mem_resp_data,
  input  logic                              vec_rd_en,
  input  logic [$clog2(MAX_LINES*16)-1:0]   vec_rd_idx,
  output logic [31:0]                       vec_rd_data,
  output logic                              vec_rd_valid
);
  localparam int IDXW = $clog2(MAX_LINES * 16);
  localparam int LW   = IDXW - 4;
  localparam int CW   = $clog2(MAX_OUT) + 1;
`ifdef SPMV_PF_MULTI_OUTSTANDING_EN
  localparam int OUT_LIM = MAX_OUT;
`else
  localparam int OUT_LIM = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         r_state;
  logic [6:0]     r_k;
  logic [6:0]     r_nlines;
  logic [CW-1:0]  r_out;
  logic [63:0]    r_pend;
  logic           r_loaded;
  logic [39:0]    r_base;
  logic [15:0]    r_len;
  logic           r_req_val;
  logic [5:0]     r_req_transid;
  logic [39:0]    r_req_addr;
  logic           r_done;
  logic           r_err;
  logic           r_rd_valid;
  logic [31:0]    r_rd_data;
  logic [511:0]   r_buf [MAX_LINES];

  logic           w_fire;
  logic           w_resp_hit;
  logic           w_resp_bad;
  logic [CW-1:0]  w_out_nxt;
  logic [6:0]     w_k_nxt;
  logic [63:0]    w_pend_set;
  logic [63:0]    w_pend_clr;
  logic [16:0]    w_start_nlines;
  logic           w_start_bad;
  logic           w_can_issue;
  logic [LW-1:0]  w_wr_line;
  logic [LW-1:0]  w_rd_line;
  logic [3:0]     w_rd_sel;
  logic           w_rd_ok;
  logic [31:0]    w_rd_word;

  assign w_fire      = r_req_val & mem_req_rdy;
  assign w_resp_hit  = mem_resp_val & r_pend[mem_resp_transid];
  assign w_resp_bad  = mem_resp_val & ~r_pend[mem_resp_transid];
  // A handshake and a response in the same cycle cancel out here.
  assign w_out_nxt   = r_out + CW'(w_fire) - CW'(w_resp_hit);
  assign w_k_nxt     = r_k + 7'(w_fire);
  assign w_pend_set  = w_fire ? (64'd1 << r_k[5:0]) : 64'd0;
  assign w_pend_clr  = w_resp_hit ? (64'd1 << mem_resp_transid) : 64'd0;
  assign w_start_nlines = ({1'b0, start_len} + 17'd15) >> 4;
  assign w_start_bad = (start_addr[5:0] != 6'd0) || (w_start_nlines > 17'(MAX_LINES));
  // mem_req_val is registered, so decide from next-cycle k and outstanding count.
  assign w_can_issue = (w_k_nxt < r_nlines) && (w_out_nxt < CW'(OUT_LIM));
  assign w_wr_line   = mem_resp_transid[LW-1:0];
  assign w_rd_line   = vec_rd_idx[IDXW-1:4];
  assign w_rd_sel    = vec_rd_idx[3:0];
  assign w_rd_ok     = vec_rd_en & r_loaded & (17'(vec_rd_idx) < {1'b0, r_len});
  assign w_rd_word   = r_buf[w_rd_line][{w_rd_sel, 5'b0} +: 32];

  assign start_rdy       = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign err             = r_err;
  assign mem_req_val     = r_req_val;
  assign mem_req_transid = r_req_transid;
  assign mem_req_addr    = r_req_addr;
  assign vec_rd_valid    = r_rd_valid;
  assign vec_rd_data     = r_rd_data;

  // Sequencing FSM with request tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_nlines      <= '0;
      r_out         <= '0;
      r_pend        <= '0;
      r_loaded      <= 1'b0;
      r_base        <= '0;
      r_len         <= '0;
      r_req_val     <= 1'b0;
      r_req_transid <= '0;
      r_req_addr    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_resp_bad;
      r_out  <= w_out_nxt;
      r_k    <= w_k_nxt;
      r_pend <= (r_pend | w_pend_set) & ~w_pend_clr;
      case (r_state)
        S_IDLE: begin
          if (start_val) begin
            if (w_start_bad) begin
              r_err <= 1'b1;
            end else begin
              r_len    <= start_len;
              r_nlines <= w_start_nlines[6:0];
              r_base   <= start_addr;
              r_k      <= '0;
              if (start_len == 16'd0) begin
                r_state <= S_DONE;
              end else begin
                r_loaded      <= 1'b0;
                r_state       <= S_ISSUE;
                r_req_val     <= 1'b1;
                r_req_addr    <= start_addr;
                r_req_transid <= '0;
              end
            end
          end
        end
        S_ISSUE: begin
          r_req_val     <= w_can_issue;
          r_req_addr    <= r_base + {27'd0, w_k_nxt, 6'd0};
          r_req_transid <= w_k_nxt[5:0];
          if (w_k_nxt == r_nlines) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_out_nxt == '0) r_state <= S_DONE;
        end
        default: begin
          r_done   <= 1'b1;
          r_loaded <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Line buffer write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_resp_hit) r_buf[w_wr_line] <= mem_resp_data;
  end

  // Element read port, one cycle latency, data forced to zero when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_data  <= w_rd_ok ? w_rd_word : 32'd0;
    end
  end
endmodule

// File: tb/tb_spmv_vec_prefetch.sv
// Bench for spmv_vec_prefetch: directed and randomized prefetch runs against
// a queue-based memory/buffer model. Honors SPMV_PF_MULTI_OUTSTANDING_EN.
module tb_spmv_vec_prefetch;
  localparam int MAX_LINES = 16;
  localparam int MAX_OUT   = 8;
`ifdef SPMV_PF_MULTI_OUTSTANDING_EN
  localparam int LIM = MAX_OUT;
`else
  localparam int LIM = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_val = 1'b0;
  logic         start_rdy;
  logic [39:0]  start_addr = '0;
  logic [15:0]  start_len = '0;
  logic         busy, done, err;
  logic         mem_req_val;
  logic         mem_req_rdy = 1'b1;
  logic [5:0]   mem_req_transid;
  logic [39:0]  mem_req_addr;
  logic         mem_resp_val = 1'b0;
  logic [5:0]   mem_resp_transid = '0;
  logic [511:0] mem_resp_data = '0;
  logic         vec_rd_en = 1'b0;
  logic [7:0]   vec_rd_idx = '0;
  logic [31:0]  vec_rd_data;
  logic         vec_rd_valid;

  spmv_vec_prefetch #(.MAX_LINES(MAX_LINES), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .start_val(start_val), .start_rdy(start_rdy),
    .start_addr(start_addr), .start_len(start_len),
    .busy(busy), .done(done), .err(err),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
    .mem_resp_data(mem_resp_data),
    .vec_rd_en(vec_rd_en), .vec_rd_idx(vec_rd_idx),
    .vec_rd_data(vec_rd_data), .vec_rd_valid(vec_rd_valid)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [511:0] exp_buf [64];
  bit           loaded_m = 1'b0;
  int           len_m = 0;
  logic [5:0]   out_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start_val = 1'b0; mem_resp_val = 1'b0; vec_rd_en = 1'b0; mem_req_rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_start_rdy", start_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req_val", mem_req_val, 0);
    chk("rst_req_transid", mem_req_transid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_rd_valid", vec_rd_valid, 0);
    rst = 1'b0;
    loaded_m = 1'b0;
  endtask

  // rmode: 0 in-order asap, 1 random, 2 order 3,1,0,2, 3 never, 4 only when blocked
  // rdymode: 0 always ready, 1 random (plus ignored start attempts), 2 stall 5 cycles
  task automatic run_op(input logic [39:0] base, input logic [15:0] len,
                        input int rmode, input int rdymode, input int max_cyc);
    int nl, nreq, nresp, ndone, maxq, stall, cyc, pick;
    bit prev_stall, resp_ok;
    int ord [4];
    logic [511:0] line;
    ord = '{3, 1, 0, 2};
    nl = (int'(len) + 15) / 16;
    nreq = 0; nresp = 0; ndone = 0; maxq = 0; stall = 5; cyc = 0; pick = 0;
    prev_stall = 1'b0;
    out_q.delete();
    chk("start_rdy_idle", start_rdy, 1);
    start_addr = base; start_len = len; start_val = 1'b1;
    if (len != 0) loaded_m = 1'b0;
    @(negedge clk);
    start_val = 1'b0;
    while (cyc < max_cyc && ndone == 0) begin
      mem_resp_val = 1'b0;
      chk("err_quiet", err, 0);
      if (done) begin
        ndone++;
        chk("done_after_all_resp", nresp, nl);
        chk("done_after_all_req", nreq, nl);
        loaded_m = 1'b1;
        len_m = int'(len);
      end else begin
        chk("busy_during_op", busy, 1);
      end
      if (prev_stall) chk("stall_hold_val", mem_req_val, 1);
      if (mem_req_val) begin
        chk("req_addr", mem_req_addr, base + 64 * nreq);
        chk("req_transid", mem_req_transid, nreq);
        chk("req_under_limit", out_q.size() < LIM, 1);
        chk("req_count_bound", nreq < nl, 1);
      end
      if (rdymode == 1 && !done) begin
        start_val  = 1'($urandom_range(0, 1));
        start_addr = base + 40'd4;
        start_len  = 16'd1;
      end else begin
        start_val = 1'b0;
      end
      case (rdymode)
        0: mem_req_rdy = 1'b1;
        1: mem_req_rdy = 1'($urandom_range(0, 1));
        default: begin
          if (mem_req_val && stall > 0) begin
            mem_req_rdy = 1'b0;
            stall--;
          end else begin
            mem_req_rdy = 1'b1;
          end
        end
      endcase
      prev_stall = mem_req_val && !mem_req_rdy;
      resp_ok = 1'b0;
      case (rmode)
        0: if (out_q.size() > 0) begin pick = 0; resp_ok = 1'b1; end
        1: if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
             pick = int'($urandom_range(0, out_q.size() - 1)); resp_ok = 1'b1;
           end
        2: if (nresp < 4) begin
             for (int i = 0; i < out_q.size(); i++)
               if (int'(out_q[i]) == ord[nresp]) begin pick = i; resp_ok = 1'b1; end
           end
        4: if (out_q.size() > 0 && (out_q.size() == LIM || nreq == nl)) begin
             pick = 0; resp_ok = 1'b1;
           end
        default: resp_ok = 1'b0;
      endcase
      if (resp_ok) begin
        line = rand_line();
        exp_buf[out_q[pick]] = line;
        mem_resp_val = 1'b1;
        mem_resp_transid = out_q[pick];
        mem_resp_data = line;
        out_q.delete(pick);
        nresp++;
      end
      if (mem_req_val && mem_req_rdy) begin
        out_q.push_back(6'(nreq));
        nreq++;
      end
      if (out_q.size() > maxq) maxq = out_q.size();
      @(negedge clk);
      cyc++;
    end
    start_val = 1'b0;
    mem_resp_val = 1'b0;
    mem_req_rdy = 1'b1;
    if (rmode != 3) begin
      chk("done_seen", ndone, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", start_rdy, 1);
      chk("not_busy_after_done", busy, 0);
    end
    if (rmode == 4) chk("max_outstanding", maxq, (LIM < nl) ? LIM : nl);
  endtask

  task automatic rd_check(input int idx, input bit en);
    bit v;
    logic [31:0] e;
    vec_rd_en = en;
    vec_rd_idx = idx[7:0];
    @(negedge clk);
    vec_rd_en = 1'b0;
    v = en && loaded_m && (idx < len_m);
    e = v ? exp_buf[idx / 16][32 * (idx % 16) +: 32] : 32'd0;
    chk("rd_valid", vec_rd_valid, v);
    chk("rd_data", vec_rd_data, e);
  endtask

  task automatic rd_random(input int n);
    for (int i = 0; i < n; i++) rd_check(int'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic bad_start(input logic [39:0] base, input logic [15:0] len);
    start_addr = base; start_len = len; start_val = 1'b1;
    @(negedge clk);
    start_val = 1'b0;
    chk("bad_err_pulse", err, 1);
    chk("bad_stay_idle", start_rdy, 1);
    chk("bad_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bad_no_req", mem_req_val, 0);
      @(negedge clk);
      chk("bad_err_one_cycle", err, 0);
    end
  endtask

  initial begin
    logic [39:0] rbase;
    int exp_stale;
    @(negedge clk);
    do_reset();

    // basic in-order fetch of 40 elements
    run_op(40'h1000, 16'd40, 0, 0, 500);
    rd_check(39, 1'b1);
    rd_check(40, 1'b1);
    rd_check(0, 1'b1);
    rd_check(39, 1'b0);
    rd_random(6);

    // rejected starts leave buffer and loaded state intact
    bad_start(40'h1004, 16'd40);
    bad_start(40'h2000, 16'd257);
    rd_check(39, 1'b1);
    rd_check(17, 1'b1);

    // out-of-order responses
`ifdef SPMV_PF_MULTI_OUTSTANDING_EN
    run_op(40'h4000, 16'd64, 2, 0, 500);
`else
    run_op(40'h4000, 16'd64, 0, 0, 500);
`endif
    rd_check(0, 1'b1);
    rd_check(63, 1'b1);
    rd_check(64, 1'b1);
    rd_random(8);

    // zero-length vector
    start_addr = 40'h5000; start_len = 16'd0; start_val = 1'b1;
    @(negedge clk);
    start_val = 1'b0;
    chk("len0_no_req_a", mem_req_val, 0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_no_req_b", mem_req_val, 0);
    loaded_m = 1'b1; len_m = 0;
    rd_check(0, 1'b1);

    // ready stall holds address/transid
    run_op(40'h8000, 16'd48, 0, 2, 500);
    rd_random(6);

    // outstanding limit reached but never exceeded
    run_op(40'h10000, 16'd256, 4, 0, 3000);
    rd_check(255, 1'b1);
    rd_random(8);

    // randomized operations
    for (int t = 0; t < 6; t++) begin
      rbase = 40'($urandom) << 6;
      run_op(rbase, 16'($urandom_range(1, 256)), 1, 1, 3000);
      rd_random(8);
    end

    // reset with reads in flight, then stale responses
    run_op(40'hA000, 16'd32, 3, 0, 6);
    exp_stale = (LIM < 2) ? LIM : 2;
    chk("reset_test_outstanding", out_q.size(), exp_stale);
    do_reset();
    while (out_q.size() > 0) begin
      mem_resp_val = 1'b1;
      mem_resp_transid = out_q.pop_front();
      mem_resp_data = rand_line();
      @(negedge clk);
      mem_resp_val = 1'b0;
      chk("stale_err", err, 1);
      chk("stale_busy", busy, 0);
      chk("stale_no_req", mem_req_val, 0);
    end
    rd_check(0, 1'b1);

    // recovery after reset
    run_op(40'hC000, 16'd32, 1, 0, 500);
    rd_random(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
